// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and valid/ack key hand-off.
// Columns are driven low one at a time; rows (active-low, pulled up) are read back
// through a 2-flop synchronizer. One key code is produced per debounced press.
// Optional feature macro: KEYPAD_ENTRY_EN builds the 16-bit nibble-entry shift register;
// without it entry_word is tied to zero.
module keypad_scanner #(
    parameter int COL_DWELL       = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ack,
    output logic        overrun,
    output logic [15:0] entry_word
);

    localparam int DW  = $clog2(COL_DWELL);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(COL_DWELL - 1);
    localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t          state_reg, state_next;
    logic [3:0]      rs_meta_reg, rs_reg;
    logic [DW-1:0]   dwell_cnt_reg, dwell_cnt_next;
    logic [DBW-1:0]  deb_cnt_reg, deb_cnt_next;
    logic [1:0]      col_idx_reg, col_idx_next;
    logic [1:0]      row_idx_reg, row_idx_next;
    logic [3:0]      pattern_reg, pattern_next;
    logic [3:0]      col_out_reg, col_out_next;
    logic [3:0]      key_code_reg, key_code_next;
    logic            key_valid_reg, key_valid_next;
    logic            overrun_reg, overrun_next;

    logic [2:0]      low_cnt;
    logic [1:0]      low_idx;
    logic            single_low;
    logic            last_dwell;
    logic            pattern_match;
    logic            deb_done;
    logic            rel_done;
    logic            accept;
    logic            accept_take;
    logic [3:0]      code_new;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_meta_reg <= 4'hF;
            rs_reg      <= 4'hF;
        end else begin
            rs_meta_reg <= row_in;
            rs_reg      <= rs_meta_reg;
        end
    end

    // Count low rows and remember which one; more than one low row is a ghost/multi-key
    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (!rs_reg[i]) begin
                low_cnt = low_cnt + 3'd1;
                low_idx = 2'(i);
            end
        end
    end

    assign single_low    = (low_cnt == 3'd1);
    assign last_dwell    = (dwell_cnt_reg == DWELL_LAST);
    assign pattern_match = (rs_reg == pattern_reg);
    assign deb_done      = pattern_match && (deb_cnt_reg == DEB_LAST);
    assign rel_done      = (rs_reg == 4'hF) && (deb_cnt_reg == DEB_LAST);
    assign accept        = (state_reg == DEBOUNCE) && deb_done;
    assign accept_take   = accept && (!key_valid_reg || key_ack);
    assign code_new      = {row_idx_reg, col_idx_reg};

    // Column decode: the active column is the only one driven low
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col_dec
            assign col_out_next[gi] = (col_idx_next != 2'(gi));
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= SCAN;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SCAN: begin
                if (last_dwell && single_low) begin
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!pattern_match) begin
                    state_next = SCAN;
                end else if (deb_done) begin
                    state_next = HELD;
                end
            end
            HELD: begin
                if (rel_done) begin
                    state_next = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // FSM output logic: counters, column, latched row and key hand-off next values
    always_comb begin
        dwell_cnt_next = dwell_cnt_reg;
        deb_cnt_next   = deb_cnt_reg;
        col_idx_next   = col_idx_reg;
        row_idx_next   = row_idx_reg;
        pattern_next   = pattern_reg;
        key_code_next  = key_code_reg;
        key_valid_next = key_valid_reg;
        overrun_next   = overrun_reg;

        case (state_reg)
            SCAN: begin
                if (last_dwell) begin
                    dwell_cnt_next = '0;
                    if (single_low) begin
                        pattern_next = rs_reg;
                        row_idx_next = low_idx;
                        deb_cnt_next = '0;
                    end else begin
                        col_idx_next = col_idx_reg + 2'd1;
                    end
                end else begin
                    dwell_cnt_next = dwell_cnt_reg + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!pattern_match) begin
                    deb_cnt_next   = '0;
                    col_idx_next   = col_idx_reg + 2'd1;
                    dwell_cnt_next = '0;
                end else if (deb_done) begin
                    deb_cnt_next = '0;
                end else begin
                    deb_cnt_next = deb_cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (rs_reg != 4'hF) begin
                    deb_cnt_next = '0;
                end else if (rel_done) begin
                    deb_cnt_next   = '0;
                    col_idx_next   = 2'd0;
                    dwell_cnt_next = '0;
                end else begin
                    deb_cnt_next = deb_cnt_reg + 1'b1;
                end
            end
            default: begin
                deb_cnt_next   = '0;
                dwell_cnt_next = '0;
            end
        endcase

        // Hand-off: a new key wins over an ack in the same cycle
        if (accept) begin
            if (accept_take) begin
                key_code_next  = code_new;
                key_valid_next = 1'b1;
                if (key_valid_reg && key_ack) begin
                    overrun_next = 1'b0;
                end
            end else begin
                overrun_next = 1'b1;
            end
        end else if (key_valid_reg && key_ack) begin
            key_valid_next = 1'b0;
            overrun_next   = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_cnt_reg <= '0;
            deb_cnt_reg   <= '0;
            col_idx_reg   <= 2'd0;
            row_idx_reg   <= 2'd0;
            pattern_reg   <= 4'hF;
            col_out_reg   <= 4'b1110;
            key_code_reg  <= 4'h0;
            key_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            dwell_cnt_reg <= dwell_cnt_next;
            deb_cnt_reg   <= deb_cnt_next;
            col_idx_reg   <= col_idx_next;
            row_idx_reg   <= row_idx_next;
            pattern_reg   <= pattern_next;
            col_out_reg   <= col_out_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            overrun_reg   <= overrun_next;
        end
    end

`ifdef KEYPAD_ENTRY_EN
    logic [15:0] entry_word_reg;

    // Nibble-entry shift register; oldest nibble leaves through the top
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_word_reg <= 16'h0000;
        end else if (accept_take) begin
            entry_word_reg <= {entry_word_reg[11:0], code_new};
        end
    end

    assign entry_word = entry_word_reg;
`else
    assign entry_word = 16'h0000;
`endif

    assign col_out   = col_out_reg;
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign overrun   = overrun_reg;

endmodule
